// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract computed one 4-bit ripple slice per cycle, LSB nibble first.
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin      operands and carry-in (carry-in ignored when in_sub=1)
//   in_sub                  1 selects A - B (B inverted, carry-in forced to 1)
//   out_valid/out_ready     result handshake (out_valid high only in DONE)
//   out_sum, out_cout       result and carry out of the MSB (for sub: 1 = no borrow)
//   out_ovf                 signed overflow
//   busy                    high while an operation is in RUN or DONE
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW+1:0] off;
    logic [3:0] sa, sbn, ss;
    logic [4:0] c;
    logic last;
    // Shared 4-bit ripple slice; the operand nibble is picked by shifting so any WIDTH works.
    always_comb begin
        off = {idx_q, 2'b00};
        sa = 4'(a_q >> off);
        sbn = 4'(b_q >> off);
        c = '0;
        ss = '0;
        c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            ss[i] = sa[i] ^ sbn[i] ^ c[i];
            c[i+1] = (sa[i] & sbn[i]) | (c[i] & (sa[i] ^ sbn[i]));
        end
        last = idx_q == IW'(NIBBLES - 1);
    end
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        carry_d = carry_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d = in_a;
                b_d = in_b ^ {WIDTH{in_sub}};
                carry_d = in_sub | in_cin;
                idx_d = '0;
                sum_d = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d = (sum_q & ~(WIDTH'(4'hf) << off)) | (WIDTH'(ss) << off);
                carry_d = c[4];
                idx_d = idx_q + IW'(1);
                if (last) begin
                    cout_d = c[4];
                    // A^Bm^sum at the MSB is the carry into the MSB, so overflow is c[3]^c[4].
                    ovf_d = c[3] ^ c[4];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
            idx_q <= idx_d;
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign out_sum = sum_q;
    assign out_cout = cout_q;
    assign out_ovf = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed scoreboard bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_cout, out_ovf, busy;
    logic [15:0] out_sum;
    int n_chk = 0, n_fail = 0;
    exp_t sb[$];
    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic [15:0] bm;
        logic [16:0] full;
        exp_t e;
        bm = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bm} + 17'(sub | cin);
        e.s = full[15:0];
        e.c = full[16];
        e.v = (a[15] == bm[15]) && (full[15] != a[15]);
        return e;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        in_valid = 1'b1;
        tick();
        sb.push_back(model(a, b, cin, sub));
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
        chk("busy_in_run", busy, 1);
        chk("in_ready_in_run", in_ready, 0);
    endtask
    task automatic finish_op(input int hold, input bit stall_new);
        int lat = 0;
        exp_t e;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, 4);
        e = sb.pop_front();
        chk("sum", out_sum, e.s);
        chk("cout", out_cout, e.c);
        chk("ovf", out_ovf, e.v);
        for (int i = 0; i < hold; i++) begin
            if (stall_new) begin
                in_valid = 1'b1;
                in_a = 16'h1234;
                in_b = 16'h1111;
                in_cin = 1'b0;
                in_sub = 1'b0;
            end
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, e.s);
            chk("bp_cout", out_cout, e.c);
            chk("bp_ovf", out_ovf, e.v);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("busy_drop", busy, 0);
        chk("sum_readable", out_sum, e.s);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        start_op(16'h00ff, 16'h0001, 1'b0, 1'b0);
        finish_op(0, 1'b0);
        start_op(16'hffff, 16'h0001, 1'b0, 1'b0);
        finish_op(0, 1'b0);
        start_op(16'hffff, 16'h0001, 1'b1, 1'b0);
        finish_op(0, 1'b0);
        start_op(16'h7fff, 16'h0001, 1'b0, 1'b0);
        finish_op(0, 1'b0);
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        finish_op(0, 1'b0);
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        finish_op(5, 1'b1);
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        finish_op(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            finish_op(i, 1'b0);
        end
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_valid", out_valid, 0);
        chk("abort_sum", out_sum, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cout", out_cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_op(16'hfffe, 16'h0003, 1'b0, 1'b0);
        finish_op(1, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
